// File: rtl/pipe_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_wb_arbiter_pkg
//  Description : Shared widths, constants and types for the write-back
//                arbiter slice (register address/data widths, the buffered
//                mul/div result entry).
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // One buffered mul/div result: destination register plus value.
  typedef struct packed {
    reg_addr_t rn;
    data_t     data;
  } md_entry_t;

endpackage : pipe_wb_arbiter_pkg
`default_nettype wire

// File: rtl/pipe_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_wb_arbiter_if
//  Description : Bundle of all non-clock signals around the write-back
//                arbiter: W-stage write request, mul/div result handshake,
//                register-file write port, pipeline freeze and the ID-stage
//                pending-destination lookup.
//                  slave  : the arbiter side
//                  master : the surrounding pipeline / mul/div unit side
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipe_wb_arbiter_if;
  import pipe_wb_arbiter_pkg::*;

  // W-stage write request
  logic      wwreg;
  reg_addr_t wrn;
  data_t     wdata;
  // mul/div result handshake
  logic      md_valid;
  reg_addr_t md_rn;
  data_t     md_data;
  logic      md_ready;
  // register-file write port
  logic      rf_we;
  reg_addr_t rf_wn;
  data_t     rf_d;
  // pipeline freeze
  logic      stall;
  // ID-stage lookup
  reg_addr_t drs;
  reg_addr_t drt;
  logic      pend_rs;
  logic      pend_rt;

  modport slave (
    input  wwreg, wrn, wdata,
    input  md_valid, md_rn, md_data,
    output md_ready,
    output rf_we, rf_wn, rf_d,
    output stall,
    input  drs, drt,
    output pend_rs, pend_rt
  );

  modport master (
    output wwreg, wrn, wdata,
    output md_valid, md_rn, md_data,
    input  md_ready,
    input  rf_we, rf_wn, rf_d,
    input  stall,
    output drs, drt,
    input  pend_rs, pend_rt
  );

endinterface : pipe_wb_arbiter_if
`default_nettype wire

// File: rtl/pipe_wb_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_wb_fifo
//  Description : Small circular buffer for mul/div results awaiting the
//                register-file write port. Exposes the head entry, the
//                occupancy and per-slot valid/destination vectors so the
//                owner can run a pending-register compare over all slots.
//  Ports       : clk, clrn       clock / async active-low reset
//                push, push_entry enqueue request and payload
//                pop              dequeue the head
//                count            registered occupancy, 0..DEPTH
//                head             entry at the read pointer
//                ent_valid/ent_rn per physical slot: occupied / destination
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_wb_fifo
  import pipe_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                                clk,
  input  wire logic                                clrn,
  input  wire logic                                push,
  input  wire md_entry_t                           push_entry,
  input  wire logic                                pop,
  output logic [$clog2(DEPTH+1)-1:0]               count,
  output md_entry_t                                head,
  output logic [DEPTH-1:0]                         ent_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]             ent_rn
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  md_entry_t        r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= push_entry;
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // A slot is live when its distance ahead of the read pointer is below count.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      logic [PW-1:0] w_off;
      assign w_off        = PW'(i) - r_rd_ptr;
      assign ent_valid[i] = (CW'(w_off) < r_count);
      assign ent_rn[i]    = r_mem[i].rn;
    end
  endgenerate

endmodule : pipe_wb_fifo
`default_nettype wire

// File: rtl/pipe_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_wb_arbiter
//  Description : Shares the single register-file write port between the
//                pipeline W stage and buffered mul/div results. Buffered
//                results fill idle port cycles; if the head is refused the
//                port MAX_WAIT times in a row, a one-cycle pipeline freeze
//                forces it out. Also flags ID-stage sources that match a
//                buffered destination.
//  Ports       : clk, clrn  clock / async active-low reset
//                bus        pipe_wb_arbiter_if.slave:
//                           wwreg/wrn/wdata        W-stage write request
//                           md_valid/md_rn/md_data mul/div result (md_ready)
//                           rf_we/rf_wn/rf_d       register-file write port
//                           stall                  pipeline freeze
//                           drs/drt -> pend_rs/rt  pending-destination lookup
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_wb_arbiter
  import pipe_wb_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  wire logic         clk,
  input  wire logic         clrn,
  pipe_wb_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int WW = $clog2(MAX_WAIT+1);
  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [WW-1:0] C_MAX_WAIT = WW'(MAX_WAIT);

  logic [CW-1:0]              w_count;
  md_entry_t                  w_head;
  md_entry_t                  w_push_entry;
  logic [DEPTH-1:0]           w_ent_valid;
  logic [DEPTH-1:0][REG_AW-1:0] w_ent_rn;

  logic          w_has;
  logic          w_ready;
  logic          w_pipe_wr;
  logic          w_stall;
  logic          w_push;
  logic          w_pop;
  logic [WW-1:0] r_wait;

  // --------------------------------------------------------------------------
  // Result buffer
  // --------------------------------------------------------------------------
  assign w_push_entry.rn   = bus.md_rn;
  assign w_push_entry.data = bus.md_data;

  pipe_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .clrn       (clrn),
    .push       (w_push),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .count      (w_count),
    .head       (w_head),
    .ent_valid  (w_ent_valid),
    .ent_rn     (w_ent_rn)
  );

  // --------------------------------------------------------------------------
  // Handshake and grant decisions
  // --------------------------------------------------------------------------
  assign w_has     = (w_count != '0);
  // Decoded from the registered count only: a same-cycle dequeue does not
  // open a slot until the next cycle, keeping md_ready off the grant path.
  assign w_ready   = (w_count < C_DEPTH);
  assign w_pipe_wr = bus.wwreg & (bus.wrn != REG_ZERO);
  assign w_stall   = w_has & (r_wait == C_MAX_WAIT);
  // Results addressed to r0 are acknowledged but never stored.
  assign w_push    = bus.md_valid & w_ready & (bus.md_rn != REG_ZERO);
  // Head drains on a forced freeze or whenever the pipeline leaves the port idle.
  assign w_pop     = w_has & (w_stall | ~w_pipe_wr);

  always_comb begin
    bus.md_ready = w_ready;
    bus.stall    = w_stall;
    bus.rf_we    = 1'b0;
    bus.rf_wn    = REG_ZERO;
    bus.rf_d     = '0;
    if (w_pop) begin
      bus.rf_we = 1'b1;
      bus.rf_wn = w_head.rn;
      bus.rf_d  = w_head.data;
    end else if (w_pipe_wr) begin
      bus.rf_we = 1'b1;
      bus.rf_wn = bus.wrn;
      bus.rf_d  = bus.wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles the head lost to the W stage.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_wait <= '0;
    end else if (w_pop || !w_has) begin
      r_wait <= '0;
    end else if (w_pipe_wr && !w_stall && (r_wait != C_MAX_WAIT)) begin
      r_wait <= r_wait + WW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Pending-destination lookup over live slots; an entry leaving this cycle
  // is still in storage and so still reports pending.
  // --------------------------------------------------------------------------
  always_comb begin
    bus.pend_rs = 1'b0;
    bus.pend_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_ent_valid[i] && (w_ent_rn[i] == bus.drs)) bus.pend_rs = 1'b1;
      if (w_ent_valid[i] && (w_ent_rn[i] == bus.drt)) bus.pend_rt = 1'b1;
    end
    if (bus.drs == REG_ZERO) bus.pend_rs = 1'b0;
    if (bus.drt == REG_ZERO) bus.pend_rt = 1'b0;
  end

endmodule : pipe_wb_arbiter
`default_nettype wire

// File: tb/tb_pipe_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_wb_arbiter
//  Description : Self-checking bench for pipe_wb_arbiter. Directed scenarios
//                followed by randomized traffic, all compared against a
//                queue-based reference of the write-port sharing rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_wb_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic clrn;

  pipe_wb_arbiter_if bus ();

  pipe_wb_arbiter #(
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int stall_seen;

  // Reference state: buffered results in arrival order and the refusal count.
  logic [4:0]  q_rn [$];
  logic [31:0] q_d  [$];
  int          m_wait;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare all outputs against the reference,
  // then advance the reference across the rising edge.
  task automatic step(input logic ww, input logic [4:0] wn, input logic [31:0] wd,
                      input logic mv, input logic [4:0] mrn, input logic [31:0] md,
                      input logic [4:0] rs, input logic [4:0] rt, output logic acc);
    logic        e_ready, e_stall, e_we, e_prs, e_prt, pipe, take;
    logic [4:0]  e_wn;
    logic [31:0] e_d;
    int          n;
    bus.wwreg = ww;  bus.wrn = wn;  bus.wdata = wd;
    bus.md_valid = mv;  bus.md_rn = mrn;  bus.md_data = md;
    bus.drs = rs;  bus.drt = rt;
    #1;
    n       = q_rn.size();
    e_ready = (n < DEPTH);
    e_stall = (n > 0) && (m_wait == MAX_WAIT);
    pipe    = ww && (wn != 5'd0);
    take    = (n > 0) && (e_stall || !pipe);
    if (take) begin
      e_we = 1'b1; e_wn = q_rn[0]; e_d = q_d[0];
    end else if (pipe) begin
      e_we = 1'b1; e_wn = wn; e_d = wd;
    end else begin
      e_we = 1'b0; e_wn = 5'd0; e_d = 32'd0;
    end
    e_prs = 1'b0;
    e_prt = 1'b0;
    foreach (q_rn[i]) begin
      if (rs != 5'd0 && q_rn[i] == rs) e_prs = 1'b1;
      if (rt != 5'd0 && q_rn[i] == rt) e_prt = 1'b1;
    end
    if (bus.stall === 1'b1) stall_seen++;
    check("md_ready", 32'(bus.md_ready), 32'(e_ready));
    check("stall",    32'(bus.stall),    32'(e_stall));
    check("rf_we",    32'(bus.rf_we),    32'(e_we));
    check("rf_wn",    32'(bus.rf_wn),    32'(e_wn));
    check("rf_d",     bus.rf_d,          e_d);
    check("pend_rs",  32'(bus.pend_rs),  32'(e_prs));
    check("pend_rt",  32'(bus.pend_rt),  32'(e_prt));
    acc = mv && e_ready;
    @(posedge clk);
    if (take) begin
      void'(q_rn.pop_front());
      void'(q_d.pop_front());
    end
    if (acc && mrn != 5'd0) begin
      q_rn.push_back(mrn);
      q_d.push_back(md);
    end
    if (take || n == 0)                              m_wait = 0;
    else if (pipe && !e_stall && m_wait < MAX_WAIT)  m_wait++;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_md_ready"}, 32'(bus.md_ready), 32'd1);
    check({tag, "_stall"},    32'(bus.stall),    32'd0);
    check({tag, "_rf_we"},    32'(bus.rf_we),    32'd0);
    check({tag, "_rf_wn"},    32'(bus.rf_wn),    32'd0);
    check({tag, "_rf_d"},     bus.rf_d,          32'd0);
    check({tag, "_pend_rs"},  32'(bus.pend_rs),  32'd0);
  endtask

  logic acc;
  int   tries;

  initial begin
    n_vec = 0; n_err = 0; stall_seen = 0; m_wait = 0;
    bus.wwreg = 0; bus.wrn = 0; bus.wdata = 0;
    bus.md_valid = 0; bus.md_rn = 0; bus.md_data = 0;
    bus.drs = 5'd4; bus.drt = 5'd0;
    clrn = 1'b0;
    #1;
    check_reset_outputs("rst0");
    repeat (2) @(negedge clk);
    clrn = 1'b1;

    // 1: idle pipeline, single result written the next cycle
    step(0, 5'd0, 32'd0, 1, 5'd5, 32'h1234, 5'd0, 5'd0, acc);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0,    5'd5, 5'd0, acc);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0,    5'd5, 5'd0, acc);

    // 2: pipeline writes every cycle; the buffered result forces one freeze
    stall_seen = 0;
    step(1, 5'd3, 32'hAAAA_0000, 1, 5'd7, 32'h7777, 5'd0, 5'd7, acc);
    for (int k = 1; k < 10; k++)
      step(1, 5'd3, 32'hAAAA_0000 + k, 0, 5'd0, 32'd0, 5'd0, 5'd7, acc);
    check("t2_stall_cycles", 32'(stall_seen), 32'd1);

    // 3: three back-to-back results against a busy pipeline; producer holds
    for (int k = 0; k < 3; k++) begin
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 30) begin
        step(1, 5'd3, 32'h3000 + tries, 1, 5'(10 + k), 32'hB000 + k, 5'd11, 5'd12, acc);
        tries++;
      end
      check("t3_accept_timeout", 32'(acc), 32'd1);
    end
    repeat (4) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd11, 5'd12, acc);

    // 4: result to r0 is dropped; a W-stage write to r0 leaves the port to the buffer
    step(0, 5'd0, 32'd0, 1, 5'd0, 32'hDEAD, 5'd0, 5'd0, acc);
    step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0,    5'd0, 5'd0, acc);
    step(1, 5'd3, 32'h44, 1, 5'd8, 32'h8888, 5'd8, 5'd0, acc);
    step(1, 5'd0, 32'h55, 0, 5'd0, 32'd0,    5'd8, 5'd0, acc);
    step(0, 5'd0, 32'd0,  0, 5'd0, 32'd0,    5'd8, 5'd0, acc);

    // 5: pending lookup before, during and after the dequeue cycle
    step(1, 5'd3, 32'h66, 1, 5'd9, 32'h9999, 5'd9, 5'd0, acc);
    step(1, 5'd3, 32'h67, 0, 5'd0, 32'd0,    5'd9, 5'd0, acc);
    step(0, 5'd0, 32'd0,  0, 5'd0, 32'd0,    5'd9, 5'd0, acc);
    step(0, 5'd0, 32'd0,  0, 5'd0, 32'd0,    5'd9, 5'd0, acc);

    // 6: asynchronous reset with two results buffered and the counter at 3
    step(1, 5'd3, 32'h1, 1, 5'd4, 32'h4444, 5'd4, 5'd6, acc);
    step(1, 5'd3, 32'h2, 1, 5'd6, 32'h6666, 5'd4, 5'd6, acc);
    step(1, 5'd3, 32'h3, 0, 5'd0, 32'd0,    5'd4, 5'd6, acc);
    step(1, 5'd3, 32'h4, 0, 5'd0, 32'd0,    5'd4, 5'd6, acc);
    check("t6_prereset_full", 32'(bus.md_ready), 32'd0);
    bus.wwreg = 1'b0;
    bus.wrn   = 5'd0;
    #2;
    clrn = 1'b0;
    #1;
    check_reset_outputs("t6_rst");
    q_rn.delete();
    q_d.delete();
    m_wait = 0;
    @(negedge clk);
    clrn = 1'b1;
    repeat (3) step(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 5'd4, 5'd6, acc);

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           5'($urandom_range(0, 7)),
           $urandom(),
           ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0,
           5'($urandom_range(0, 7)),
           $urandom(),
           5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)),
           acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_pipe_wb_arbiter
`default_nettype wire
